// File: rtl/mips_pkg.sv
// Shared HI/LO and divider definitions: operand width, divide step count, FSM encoding and
// the small sign helper used on both sides of the unsigned divide core.
package mips_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [WIDTH-1:0] HILO_RESET = '0;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StFix
  } hilo_state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: start loads the operands, each step retires one quotient bit,
// last flags the final step so the controller can leave the divide state.
module div_core
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    // Top bit set means the trial subtraction borrowed, so the shifted value is kept.
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CNT_W'(DIV_CYCLES - 1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner: captures multiply products, MTHI/MTLO writes and iterative divide
// results, and raises busy while a divide is in flight so the pipeline stalls.
module hilo_unit
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mult_valid,
  input  logic [2*WIDTH-1:0] mult_result,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [WIDTH-1:0]   mt_data,
  input  logic               flush,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               div_done,
  output logic               div_by_zero
);

  hilo_state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic             q_neg_q, r_neg_q;
  logic             idle, div_zero, neg_a, neg_b;
  logic             core_start, core_step, core_last;
  logic [WIDTH-1:0] mag_a, mag_b, core_q, core_r;

  assign idle     = (state_q == StIdle);
  assign div_zero = (divisor == '0);
  assign neg_a    = div_signed & dividend[WIDTH-1];
  assign neg_b    = div_signed & divisor[WIDTH-1];
  assign mag_a    = cond_neg(dividend, neg_a);
  assign mag_b    = cond_neg(divisor, neg_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (core_start) state_d = StDiv;
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else if (core_last) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = !idle;
    core_start = idle & div_start & ~flush & ~div_zero;
    core_step  = (state_q == StDiv) & ~flush;
  end

  div_core u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .step      (core_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (core_q),
    .remainder (core_r),
    .last      (core_last)
  );

  // Write priority in idle: divide request, then product, then MTHI/MTLO.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    dbz_d  = 1'b0;
    if (!flush) begin
      if (state_q == StFix) begin
        hi_d   = cond_neg(core_r, r_neg_q);
        lo_d   = cond_neg(core_q, q_neg_q);
        done_d = 1'b1;
      end else if (idle) begin
        if (div_start) begin
          done_d = div_zero;
          dbz_d  = div_zero;
        end else if (mult_valid) begin
          {hi_d, lo_d} = mult_result;
        end else begin
          if (mthi) hi_d = mt_data;
          if (mtlo) lo_d = mt_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= HILO_RESET;
      lo_q    <= HILO_RESET;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      if (core_start) begin
        q_neg_q <= neg_a ^ neg_b;
        r_neg_q <= neg_a;
      end
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_done    = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed cases plus randomized operations scored against
// an arithmetic model of HI/LO.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mult_valid = 1'b0;
  logic [63:0] mult_result = '0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] mt_data = '0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, div_done, div_by_zero;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mult_valid  (mult_valid),
    .mult_result (mult_result),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .mt_data     (mt_data),
    .flush       (flush),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .div_done    (div_done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  // Reference divide done in 64-bit arithmetic so INT_MIN / -1 cannot overflow.
  function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    q  = qq[31:0];
    r  = rr[31:0];
  endfunction

  task automatic clear_inputs();
    mult_valid = 1'b0;
    div_start  = 1'b0;
    mthi       = 1'b0;
    mtlo       = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle_op(input logic mv, input logic [63:0] mr, input logic h, input logic l,
                         input logic [31:0] d, input logic fl);
    mult_valid = mv; mult_result = mr; mthi = h; mtlo = l; mt_data = d; flush = fl;
    @(negedge clk);
    clear_inputs();
    if (!fl) begin
      if (mv) {exp_hi, exp_lo} = mr;
      else begin
        if (h) exp_hi = d;
        if (l) exp_lo = d;
      end
    end
    check_regs("op");
    check("op.busy", busy, 0);
    check("op.div_done", div_done, 0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int flush_at, input bit noise);
    logic [31:0] eq, er;
    int          cyc;
    bit          flushed;
    cyc = 0;
    flushed = 0;
    eq = '0;
    er = '0;
    if (b != 0) model_div(a, b, sgn, eq, er);
    div_start = 1'b1; dividend = a; divisor = b; div_signed = sgn;
    if (noise) begin
      mult_valid = 1'b1; mult_result = {$urandom, $urandom};
    end
    @(negedge clk);
    clear_inputs();
    dividend = $urandom; divisor = $urandom; div_signed = 1'($urandom);
    while (busy && cyc < 40) begin
      cyc++;
      if (noise) begin
        mult_valid = 1'($urandom); mult_result = {$urandom, $urandom};
        mthi = 1'($urandom); mtlo = 1'($urandom); mt_data = $urandom;
        div_start = 1'($urandom);
      end
      if (cyc == flush_at) begin
        flush = 1'b1;
        flushed = 1;
      end
      @(negedge clk);
      clear_inputs();
      if (busy) begin
        check("div.early_done", div_done, 0);
        check_regs("div.hold");
      end
    end
    if (flushed) begin
      check("flush.cycles", cyc, flush_at);
      check("flush.busy", busy, 0);
      check("flush.div_done", div_done, 0);
      check_regs("flush");
      @(negedge clk);
      check("flush.late_done", div_done, 0);
      check_regs("flush.after");
    end else begin
      check("div.busy_cycles", cyc, (b == 0) ? 0 : 33);
      check("div.done", div_done, 1);
      check("div.by_zero", div_by_zero, b == 0);
      if (b != 0) begin
        exp_hi = er;
        exp_lo = eq;
      end
      check_regs("div");
      @(negedge clk);
      check("div.done_pulse", div_done, 0);
      check("div.dbz_pulse", div_by_zero, 0);
      check("div.idle_busy", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    check("rst.busy", busy, 0);
    check("rst.div_done", div_done, 0);
    check("rst.dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    idle_op(1'b1, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0, 32'h0, 1'b0);
    check("mult.hi_const", hi, 32'h1);
    run_div(32'd100, 32'd7, 1'b0, 0, 0);
    check("divu.lo_const", lo, 32'd14);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
    check("div.neg_lo", lo, 32'hFFFF_FFFD);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    check("div.wrap_lo", lo, 32'h8000_0000);

    idle_op(1'b0, 64'h0, 1'b1, 1'b0, 32'h11, 1'b0);
    idle_op(1'b0, 64'h0, 1'b0, 1'b1, 32'h22, 1'b0);
    run_div(32'h1234_5678, 32'h0, 1'b1, 0, 0);
    check("dbz.hi_const", hi, 32'h11);

    run_div(32'd50, 32'd5, 1'b0, 10, 0);
    run_div(32'd9, 32'd3, 1'b0, 0, 0);

    idle_op(1'b0, 64'h0, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
    check("mt.both", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
    idle_op(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 32'h5A5A_5A5A, 1'b0);
    idle_op(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, $urandom, 1'b1);

    // Flush in idle cancels a same-cycle divide request, including divide by zero.
    for (int k = 0; k < 2; k++) begin
      div_start = 1'b1; dividend = 32'd77; divisor = (k == 0) ? 32'd3 : 32'd0; flush = 1'b1;
      @(negedge clk);
      clear_inputs();
      check("iflush.busy", busy, 0);
      check("iflush.done", div_done, 0);
      check("iflush.dbz", div_by_zero, 0);
      @(negedge clk);
      check("iflush.busy2", busy, 0);
      check_regs("iflush");
    end

    // Asynchronous reset in the middle of a divide.
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd9; div_signed = 1'b0;
    @(negedge clk);
    clear_inputs();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check_regs("arst");
    check("arst.busy", busy, 0);
    check("arst.done", div_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst.idle", busy, 0);
    check("arst.no_done", div_done, 0);
    check_regs("arst.after");

    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
          case ($urandom_range(0, 3))
            0:       b = 32'h0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
          endcase
          run_div(a, b, 1'($urandom),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 33)) : 0,
                  1'($urandom));
        end
        2: idle_op(1'b1, {$urandom, $urandom}, 1'($urandom), 1'($urandom), $urandom,
                   1'($urandom_range(0, 3) == 0));
        default: idle_op(1'b0, 64'h0, 1'($urandom), 1'($urandom), $urandom,
                         1'($urandom_range(0, 3) == 0));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
